// File: rtl/hazard_control_if.sv
`default_nettype none
// ============================================================================
// hazard_control_pkg / hazard_control_if
// ----------------------------------------------------------------------------
// Purpose : Shared write-back type enumeration and the bundle of pipeline
//           status inputs and hazard control outputs exchanged between the
//           pipeline (master) and the hazard controller (slave).
// Ports   : master drives decode/execute status, memory handshake and
//           redirect/trap flags; slave drives stall/bubble/flush controls,
//           the timeout flag and the two performance counters.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_control_pkg;
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_PC   = 2'd3
  } writebackType_;
endpackage

interface hazard_control_if;
  import hazard_control_pkg::*;

  // Pipeline status
  logic          fetchDecodeValid;
  logic [4:0]    fetchDecodeRegister1;
  logic [4:0]    fetchDecodeRegister2;
  logic          fetchDecodeUsesRegister1;
  logic          fetchDecodeUsesRegister2;
  logic          decodeExecuteValid;
  logic [4:0]    decodeExecuteDestinationRegister;
  writebackType_ decodeExecuteWritebackType;
  logic          memoryRequest;
  logic          memoryResponseValid;
  logic          redirectValid;
  logic          trapValid;

  // Hazard controls
  logic          stallFetch;
  logic          stallDecode;
  logic          bubbleExecute;
  logic          stallMemory;
  logic          flushFetchDecode;
  logic          flushDecodeExecute;
  logic          memoryTimeout;
  logic [31:0]   loadUseCount;
  logic [31:0]   memoryStallCount;

  modport master (
    output fetchDecodeValid, fetchDecodeRegister1, fetchDecodeRegister2,
           fetchDecodeUsesRegister1, fetchDecodeUsesRegister2,
           decodeExecuteValid, decodeExecuteDestinationRegister,
           decodeExecuteWritebackType, memoryRequest, memoryResponseValid,
           redirectValid, trapValid,
    input  stallFetch, stallDecode, bubbleExecute, stallMemory,
           flushFetchDecode, flushDecodeExecute, memoryTimeout,
           loadUseCount, memoryStallCount
  );

  modport slave (
    input  fetchDecodeValid, fetchDecodeRegister1, fetchDecodeRegister2,
           fetchDecodeUsesRegister1, fetchDecodeUsesRegister2,
           decodeExecuteValid, decodeExecuteDestinationRegister,
           decodeExecuteWritebackType, memoryRequest, memoryResponseValid,
           redirectValid, trapValid,
    output stallFetch, stallDecode, bubbleExecute, stallMemory,
           flushFetchDecode, flushDecodeExecute, memoryTimeout,
           loadUseCount, memoryStallCount
  );
endinterface
`default_nettype wire

// File: rtl/hazard_control.sv
`default_nettype none
// ============================================================================
// hazard_control
// ----------------------------------------------------------------------------
// Purpose : Produces stall, bubble and flush controls for the hazards the
//           forwarding unit cannot resolve: load-use dependencies, multi-cycle
//           data-memory waits (with a bounded timeout) and branch/trap
//           redirects. Also counts load-use bubbles and memory stall cycles.
// Ports   : clk             rising-edge clock
//           rst_n           asynchronous active-low reset
//           bus (slave)     pipeline status in, hazard controls and counters out
// Params  : TIMEOUT_CYCLES  total stalled cycles allowed per memory access
//                           before memoryTimeout (minimum 2)
// Revision: 1.0 - initial release
// ============================================================================
module hazard_control #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  hazard_control_if.slave bus
);
  import hazard_control_pkg::*;

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   waitCount_q, waitCount_d;
  logic [31:0]         loadUseCount_q, loadUseCount_d;
  logic [31:0]         memoryStallCount_q, memoryStallCount_d;

  logic src1Hit, src2Hit, loadUse;
  logic stallFrontEnd, stallMem, flushBoth, timeout;

  // Load-use: a live load in decode/execute whose non-zero destination is
  // actually read by the live instruction in fetch/decode.
  assign src1Hit = bus.fetchDecodeUsesRegister1 &&
                   (bus.fetchDecodeRegister1 == bus.decodeExecuteDestinationRegister);
  assign src2Hit = bus.fetchDecodeUsesRegister2 &&
                   (bus.fetchDecodeRegister2 == bus.decodeExecuteDestinationRegister);
  assign loadUse = bus.fetchDecodeValid && bus.decodeExecuteValid &&
                   (bus.decodeExecuteWritebackType == WB_MEM) &&
                   (bus.decodeExecuteDestinationRegister != 5'd0) &&
                   (src1Hit || src2Hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= RUN;
      waitCount_q        <= '0;
      loadUseCount_q     <= '0;
      memoryStallCount_q <= '0;
    end else begin
      state_q            <= state_d;
      waitCount_q        <= waitCount_d;
      loadUseCount_q     <= loadUseCount_d;
      memoryStallCount_q <= memoryStallCount_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    waitCount_d        = waitCount_q;
    loadUseCount_d     = loadUseCount_q;
    memoryStallCount_d = memoryStallCount_q;
    stallFrontEnd      = 1'b0;
    stallMem           = 1'b0;
    flushBoth          = 1'b0;
    timeout            = 1'b0;

    if (bus.trapValid) begin
      // Trap overrides everything, including an outstanding memory wait.
      flushBoth   = 1'b1;
      state_d     = RUN;
      waitCount_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.memoryRequest && !bus.memoryResponseValid) begin
            stallMem    = 1'b1;
            state_d     = MEM_WAIT;
            waitCount_d = '0;
          end
        end
        MEM_WAIT: begin
          // waitCount holds the stalled cycles already spent in MEM_WAIT;
          // together with the RUN cycle that opened the wait this bounds the
          // access to TIMEOUT_CYCLES stalled cycles. A response wins over the
          // timeout boundary.
          if (bus.memoryResponseValid) begin
            state_d     = RUN;
            waitCount_d = '0;
          end else if (waitCount_q < WAIT_LAST) begin
            stallMem    = 1'b1;
            waitCount_d = waitCount_q + 1'b1;
          end else begin
            timeout     = 1'b1;
            state_d     = RUN;
            waitCount_d = '0;
          end
        end
        default: begin
          state_d     = RUN;
          waitCount_d = '0;
        end
      endcase

      // With the pipeline frozen by a memory stall, redirect and load-use
      // inputs are re-presented later, so they only act on unfrozen cycles.
      // A redirect squashes the wrong-path consumer, so it masks load-use.
      if (!stallMem) begin
        if (bus.redirectValid) begin
          flushBoth = 1'b1;
        end else if (loadUse) begin
          stallFrontEnd  = 1'b1;
          loadUseCount_d = loadUseCount_q + 32'd1;
        end
      end
    end

    if (stallMem) begin
      memoryStallCount_d = memoryStallCount_q + 32'd1;
    end
  end

  // Controls are Mealy; gating with rst_n forces them low the instant reset
  // is asserted rather than waiting for the state to clear.
  assign bus.stallFetch         = rst_n & stallFrontEnd;
  assign bus.stallDecode        = rst_n & stallFrontEnd;
  assign bus.bubbleExecute      = rst_n & stallFrontEnd;
  assign bus.stallMemory        = rst_n & stallMem;
  assign bus.flushFetchDecode   = rst_n & flushBoth;
  assign bus.flushDecodeExecute = rst_n & flushBoth;
  assign bus.memoryTimeout      = rst_n & timeout;
  assign bus.loadUseCount       = loadUseCount_q;
  assign bus.memoryStallCount   = memoryStallCount_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_control.sv
`default_nettype none
// ============================================================================
// tb_hazard_control
// ----------------------------------------------------------------------------
// Purpose : Self-checking bench for hazard_control. A behavioural model that
//           tracks "inside an access / stalled cycles so far" predicts every
//           control output and counter each cycle; directed scenarios add
//           hand-computed literal expectations, then random traffic follows.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_control;
  import hazard_control_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_control_if hc_if ();

  hazard_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hc_if)
  );

  int checks = 0;
  int failures = 0;

  // Model state: whether an access is outstanding and how many cycles it has
  // already been stalled, plus the two expected counters.
  bit          m_waiting = 1'b0;
  int          m_stalls = 0;
  logic [31:0] m_lu = '0;
  logic [31:0] m_ms = '0;

  logic [6:0] ctrl;
  assign ctrl = {hc_if.stallFetch, hc_if.stallDecode, hc_if.bubbleExecute,
                 hc_if.stallMemory, hc_if.flushFetchDecode,
                 hc_if.flushDecodeExecute, hc_if.memoryTimeout};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    hc_if.fetchDecodeValid                 = 1'b0;
    hc_if.fetchDecodeRegister1             = 5'd0;
    hc_if.fetchDecodeRegister2             = 5'd0;
    hc_if.fetchDecodeUsesRegister1         = 1'b0;
    hc_if.fetchDecodeUsesRegister2         = 1'b0;
    hc_if.decodeExecuteValid               = 1'b0;
    hc_if.decodeExecuteDestinationRegister = 5'd0;
    hc_if.decodeExecuteWritebackType       = WB_NONE;
    hc_if.memoryRequest                    = 1'b0;
    hc_if.memoryResponseValid              = 1'b0;
    hc_if.redirectValid                    = 1'b0;
    hc_if.trapValid                        = 1'b0;
  endtask

  // Producer writing dst in decode/execute, consumer "op xN, src, x1" in
  // fetch/decode reading src through register port 1.
  task automatic pair(input logic [4:0] src, input logic [4:0] dst,
                      input writebackType_ wb, input logic uses1);
    hc_if.fetchDecodeValid                 = 1'b1;
    hc_if.fetchDecodeRegister1             = src;
    hc_if.fetchDecodeUsesRegister1         = uses1;
    hc_if.fetchDecodeRegister2             = 5'd1;
    hc_if.fetchDecodeUsesRegister2         = 1'b1;
    hc_if.decodeExecuteValid               = 1'b1;
    hc_if.decodeExecuteDestinationRegister = dst;
    hc_if.decodeExecuteWritebackType       = wb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin : compare
    logic hazard, e_fe, e_sm, e_fl, e_to;
    if (!rst_n) begin
      chk("reset_ctrl", {25'd0, ctrl}, 32'd0);
      chk("reset_luc", hc_if.loadUseCount, 32'd0);
      chk("reset_msc", hc_if.memoryStallCount, 32'd0);
      m_waiting = 1'b0;
      m_stalls  = 0;
      m_lu      = '0;
      m_ms      = '0;
    end else begin
      hazard = hc_if.fetchDecodeValid && hc_if.decodeExecuteValid &&
               hc_if.decodeExecuteWritebackType == WB_MEM &&
               hc_if.decodeExecuteDestinationRegister != 5'd0 &&
               ((hc_if.fetchDecodeUsesRegister1 &&
                 hc_if.fetchDecodeRegister1 == hc_if.decodeExecuteDestinationRegister) ||
                (hc_if.fetchDecodeUsesRegister2 &&
                 hc_if.fetchDecodeRegister2 == hc_if.decodeExecuteDestinationRegister));
      e_fe = 1'b0; e_sm = 1'b0; e_fl = 1'b0; e_to = 1'b0;
      if (hc_if.trapValid) begin
        e_fl      = 1'b1;
        m_waiting = 1'b0;
        m_stalls  = 0;
      end else begin
        if (!m_waiting) begin
          if (hc_if.memoryRequest && !hc_if.memoryResponseValid) begin
            e_sm      = 1'b1;
            m_waiting = 1'b1;
            m_stalls  = 1;
          end
        end else if (hc_if.memoryResponseValid) begin
          m_waiting = 1'b0;
        end else if (m_stalls < TO) begin
          e_sm = 1'b1;
          m_stalls++;
        end else begin
          e_to      = 1'b1;
          m_waiting = 1'b0;
        end
        if (!e_sm) begin
          if (hc_if.redirectValid) e_fl = 1'b1;
          else if (hazard)         e_fe = 1'b1;
        end
      end
      chk("ctrl", {25'd0, ctrl}, {25'd0, e_fe, e_fe, e_fe, e_sm, e_fl, e_fl, e_to});
      chk("loadUseCount", hc_if.loadUseCount, m_lu);
      chk("memoryStallCount", hc_if.memoryStallCount, m_ms);
      m_lu = m_lu + {31'd0, e_fe};
      m_ms = m_ms + {31'd0, e_sm};
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin : stim
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("luc_init", hc_if.loadUseCount, 32'd0);

    // Load x5 then add x6,x5,x1: one bubble, then the NOP clears it.
    next_cycle();
    pair(5'd5, 5'd5, WB_MEM, 1'b1);
    @(negedge clk);
    chk("lu_stall", {29'd0, hc_if.stallFetch, hc_if.stallDecode, hc_if.bubbleExecute}, 32'd7);
    next_cycle();
    pair(5'd5, 5'd5, WB_MEM, 1'b1);
    hc_if.decodeExecuteValid = 1'b0;
    @(negedge clk);
    chk("lu_release", {29'd0, hc_if.stallFetch, hc_if.stallDecode, hc_if.bubbleExecute}, 32'd0);
    chk("luc_one", hc_if.loadUseCount, 32'd1);

    // Non-hazards: source not read, load to x0, ALU producer.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      case (k)
        0:       pair(5'd5, 5'd5, WB_MEM, 1'b0);
        1:       pair(5'd0, 5'd0, WB_MEM, 1'b1);
        default: pair(5'd5, 5'd5, WB_ALU, 1'b1);
      endcase
      @(negedge clk);
      chk("no_hazard", {31'd0, hc_if.bubbleExecute}, 32'd0);
    end

    // Memory wait answered on the 4th cycle: three stalled cycles.
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      hc_if.memoryRequest       = 1'b1;
      hc_if.memoryResponseValid = (c == 4);
      @(negedge clk);
      chk("memwait_stall", {31'd0, hc_if.stallMemory}, (c < 4) ? 32'd1 : 32'd0);
    end
    next_cycle();
    @(negedge clk);
    chk("memwait_msc", hc_if.memoryStallCount, 32'd3);
    chk("memwait_run", {31'd0, hc_if.stallMemory}, 32'd0);

    // Timeout: four stalled cycles, then a single-cycle timeout flag.
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      hc_if.memoryRequest = 1'b1;
      @(negedge clk);
      chk("to_stall", {31'd0, hc_if.stallMemory}, (c <= 4) ? 32'd1 : 32'd0);
      chk("to_flag", {31'd0, hc_if.memoryTimeout}, (c == 5) ? 32'd1 : 32'd0);
    end
    next_cycle();
    @(negedge clk);
    chk("to_once", {30'd0, hc_if.memoryTimeout, hc_if.stallMemory}, 32'd0);

    // Response in the boundary cycle wins over the timeout.
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      hc_if.memoryRequest       = 1'b1;
      hc_if.memoryResponseValid = (c == 5);
      @(negedge clk);
      chk("bnd_stall", {31'd0, hc_if.stallMemory}, (c <= 4) ? 32'd1 : 32'd0);
      chk("bnd_flag", {31'd0, hc_if.memoryTimeout}, 32'd0);
    end

    // Redirect together with load-use: flushes only.
    next_cycle();
    pair(5'd5, 5'd5, WB_MEM, 1'b1);
    hc_if.redirectValid = 1'b1;
    @(negedge clk);
    chk("redir_prio", {27'd0, hc_if.flushFetchDecode, hc_if.flushDecodeExecute,
                       hc_if.stallFetch, hc_if.stallDecode, hc_if.bubbleExecute}, 32'd24);
    next_cycle();
    @(negedge clk);
    chk("redir_luc", hc_if.loadUseCount, 32'd1);

    // Trap during MEM_WAIT.
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      hc_if.memoryRequest = 1'b1;
      hc_if.trapValid     = (c == 3);
      @(negedge clk);
    end
    chk("trap_stall", {31'd0, hc_if.stallMemory}, 32'd0);
    chk("trap_flush", {30'd0, hc_if.flushFetchDecode, hc_if.flushDecodeExecute}, 32'd3);
    next_cycle();
    @(negedge clk);
    chk("trap_run", {31'd0, hc_if.stallMemory}, 32'd0);

    // Asynchronous reset mid-MEM_WAIT.
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      hc_if.memoryRequest = 1'b1;
    end
    #1;
    chk("pre_reset_stall", {31'd0, hc_if.stallMemory}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_ctrl", {25'd0, ctrl}, 32'd0);
    chk("async_luc", hc_if.loadUseCount, 32'd0);
    chk("async_msc", hc_if.memoryStallCount, 32'd0);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_run", {31'd0, hc_if.stallMemory}, 32'd0);

    // Counter wrap.
    @(posedge clk);
    #1;
    idle();
    force dut.loadUseCount_q = 32'hFFFF_FFFF;
    m_lu = 32'hFFFF_FFFF;
    #1;
    release dut.loadUseCount_q;
    next_cycle();
    pair(5'd7, 5'd7, WB_MEM, 1'b1);
    @(negedge clk);
    chk("wrap_before", hc_if.loadUseCount, 32'hFFFF_FFFF);
    next_cycle();
    @(negedge clk);
    chk("wrap_after", hc_if.loadUseCount, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      hc_if.fetchDecodeValid                 = ($urandom_range(0, 3) != 0);
      hc_if.fetchDecodeRegister1             = 5'($urandom_range(0, 3));
      hc_if.fetchDecodeRegister2             = 5'($urandom_range(0, 3));
      hc_if.fetchDecodeUsesRegister1         = 1'($urandom_range(0, 1));
      hc_if.fetchDecodeUsesRegister2         = 1'($urandom_range(0, 1));
      hc_if.decodeExecuteValid               = ($urandom_range(0, 3) != 0);
      hc_if.decodeExecuteDestinationRegister = 5'($urandom_range(0, 3));
      hc_if.decodeExecuteWritebackType       = writebackType_'(2'($urandom_range(0, 3)));
      hc_if.memoryRequest                    = ($urandom_range(0, 2) == 0);
      hc_if.memoryResponseValid              = ($urandom_range(0, 3) == 0);
      hc_if.redirectValid                    = ($urandom_range(0, 7) == 0);
      hc_if.trapValid                        = ($urandom_range(0, 39) == 0);
    end
    next_cycle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/hazard_control.md
# hazard_control

Pipeline hazard and stall controller: the producer of the stall, bubble and flush controls that complement the forwarding unit. It covers the hazards forwarding cannot resolve:
- load-use dependencies, since load data is never forwarded from execute/memory;
- multi-cycle data-memory waits, including a bounded timeout;
- branch/jump redirects and traps.

It sits beside the forwarding unit and drives the enables of the fetch/decode, decode/execute and execute/memory pipeline registers. It also keeps two performance counters.

## Interface
- TIMEOUT_CYCLES, 256: total stall cycles allowed on one memory access before memoryTimeout; minimum 2.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- fetchDecodeValid  in  1  fetch/decode register holds a live instruction
- fetchDecodeRegister1 / fetchDecodeRegister2  in  5  decode-stage source registers
- fetchDecodeUsesRegister1 / fetchDecodeUsesRegister2  in  1  source actually read
- decodeExecuteValid  in  1  decode/execute register live
- decodeExecuteDestinationRegister  in  5  execute-stage destination
- decodeExecuteWritebackType  in  writebackType_  WB_MEM marks a load
- memoryRequest  in  1  memory stage is issuing/holding a data access
- memoryResponseValid  in  1  data memory completes the access this cycle
- redirectValid  in  1  execute resolved a taken branch/jump
- trapValid  in  1  trap/exception redirect this cycle
- stallFetch, stallDecode  out  1  hold PC and fetch/decode register
- bubbleExecute  out  1  decode/execute register loads a NOP
- stallMemory  out  1  freeze PC and the fetch/decode, decode/execute and execute/memory registers; memory/writeback loads a NOP
- flushFetchDecode, flushDecodeExecute  out  1  load NOP into that register
- memoryTimeout  out  1  access abandoned; same-cycle flag to trap logic
- loadUseCount  out  32  load-use bubbles inserted
- memoryStallCount  out  32  cycles with stallMemory high

## Operation
- State register: RUN or MEM_WAIT. waitCount is a $clog2(TIMEOUT_CYCLES)-bit counter.
- Reset: state = RUN, waitCount = 0, both counters = 0. All outputs are 0 during reset.
- loadUse, combinational: fetchDecodeValid && decodeExecuteValid && decodeExecuteWritebackType == WB_MEM && decodeExecuteDestinationRegister != 0 && ((UsesRegister1 && Register1 == dest) || (UsesRegister2 && Register2 == dest)).
- Priority, highest first: trap > memory stall > redirect > load-use.
- trapValid, any state:
  - flushFetchDecode = flushDecodeExecute = 1; every stall and bubble output = 0.
  - Next state = RUN; waitCount cleared.
- RUN:
  - memoryRequest && !memoryResponseValid: stallMemory = 1; next state MEM_WAIT with waitCount = 0. Redirect and load-use are ignored this cycle because the pipeline is frozen and the inputs are re-presented later.
  - memoryRequest && memoryResponseValid: no stall (single-cycle access).
  - Else redirectValid: flushFetchDecode = flushDecodeExecute = 1; load-use suppressed (wrong path).
  - Else loadUse: stallFetch = stallDecode = bubbleExecute = 1; loadUseCount += 1. One bubble is sufficient; the next cycle sees a NOP in decode/execute, so there is no re-detection.
- MEM_WAIT:
  - memoryResponseValid: no stall; next state RUN.
  - No response and waitCount < TIMEOUT_CYCLES-1: stallMemory = 1; waitCount += 1.
  - No response and waitCount == TIMEOUT_CYCLES-1: memoryTimeout = 1; stallMemory = 0; next state RUN.
- memoryStallCount += 1 on every cycle stallMemory is high.
- Both counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0.
- writeback-type equality uses the enum only; register 0 never creates a hazard.

## Timing
- All control outputs are Mealy: combinational from state, waitCount and same-cycle inputs. There are no registered delays.
- State, waitCount and both counters update on the rising clock edge. Counter values are visible the cycle after the event.
- An access that never completes gets exactly TIMEOUT_CYCLES stalled cycles: 1 in RUN plus TIMEOUT_CYCLES-1 in MEM_WAIT. memoryTimeout is then high for exactly one cycle.
- A response in the same cycle as the timeout boundary wins: no timeout is raised.
- Reset asserted mid-MEM_WAIT: outputs drop to 0 immediately (asynchronous). The block resumes in RUN after reset releases.
- Trap during MEM_WAIT: no stall that cycle; memoryStallCount does not increment.

## Test plan
- Load-use: load to x5 in decode/execute, add x6,x5,x1 in fetch/decode (uses1) -> one cycle of stallFetch = stallDecode = bubbleExecute = 1, then 0. loadUseCount increments 0 -> 1.
- Non-hazards:
  - same load with consumer reading x5 but UsesRegister = 0 -> no stall;
  - load to x0 -> no stall;
  - ALU writer (WB_ALU) to x5 -> no stall.
- Memory wait: memoryRequest high, memoryResponseValid high on the 4th cycle -> stallMemory high 3 cycles; memoryStallCount = 3; state back to RUN.
- Timeout with TIMEOUT_CYCLES = 4 and no response:
  - stallMemory high 4 cycles, then memoryTimeout = 1 for one cycle with stallMemory = 0.
  - Repeat with the response arriving in the boundary cycle -> memoryTimeout stays 0.
- Priority:
  - redirectValid and loadUse together -> flushes only, no bubble, loadUseCount unchanged;
  - trapValid during MEM_WAIT -> flushes, stallMemory = 0, state RUN.
- Reset and wrap:
  - async reset asserted mid-MEM_WAIT -> all outputs 0 immediately, counters 0;
  - loadUseCount forced near 0xFFFFFFFF -> wraps to 0 after the next bubble.
